// File: rtl/cory_queue_cnt.sv
// Counted FIFO with a valid/ready write side (a) and a valid/ready read side (z).
// Depth Q (>= 1), entry width N. Ready on the write side reflects the registered
// fill level only, so a pop in the same cycle never raises o_a_r combinationally.
module cory_queue_cnt #(
    parameter int N = 8,
    parameter int Q = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    output logic         o_a_r,
    input  logic [N-1:0] i_a_d,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    input  logic         i_z_r
);

    localparam int PW = (Q > 1) ? $clog2(Q) : 1;
    localparam int CW = $clog2(Q + 1);

    logic [N-1:0]  mem_q [Q];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;
    logic          pop;

    // Pointers wrap modulo Q, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(Q - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign o_a_r = (cnt_q != CW'(Q));
    assign o_z_v = (cnt_q != '0);
    assign o_z_d = mem_q[rd_ptr_q];
    assign push  = i_a_v & o_a_r;
    assign pop   = i_z_r & o_z_v;

    // Next-state for pointers and fill level; push and pop together keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, written on push.
    // NOTE: storage is deliberately not reset; the count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_a_d;
        end
    end

endmodule

// File: rtl/cory_sram_wo.sv
// Write-only SRAM adapter: buffers valid/ready write requests in a Q-deep queue,
// drains them into the SRAM write port when i_z_r allows, and returns one
// acknowledge per committed write, in order.
// Optional feature macro: CORY_SRAM_WO_ACK_EN enables the acknowledge channel and
// the outstanding-ack back-pressure; without it o_b_v/o_b_cnt are tied to 0.
module cory_sram_wo #(
    parameter int C = 2,
    parameter int A = 8,
    parameter int D = 8,
    parameter int Q = 2,
    parameter int B = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [C-1:0]             i_s_cen,
    input  logic [A-1:0]             i_s_addr,
    input  logic [D-1:0]             i_s_wdata,
    output logic                     o_s_r,
    output logic [C-1:0]             o_z_cen,
    output logic [C-1:0]             o_z_wen,
    output logic [A-1:0]             o_z_addr,
    output logic [D-1:0]             o_z_wdata,
    input  logic                     i_z_r,
    output logic                     o_b_v,
    input  logic                     i_b_r,
    output logic [$clog2(B+1)-1:0]   o_b_cnt
);

    localparam int QW = C + A + D;
    localparam int BW = $clog2(B + 1);

    logic          s_v;
    logic [QW-1:0] head_d;
    logic          head_v;
    logic [C-1:0]  head_cen;
    logic [A-1:0]  head_addr;
    logic [D-1:0]  head_wdata;
    logic          ack_ok;
    logic          issue;

    assign s_v = ~&i_s_cen;

    cory_queue_cnt #(
        .N (QW),
        .Q (Q)
    ) u_req_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_a_v   (s_v),
        .o_a_r   (o_s_r),
        .i_a_d   ({i_s_cen, i_s_addr, i_s_wdata}),
        .o_z_v   (head_v),
        .o_z_d   (head_d),
        .i_z_r   (issue)
    );

    assign {head_cen, head_addr, head_wdata} = head_d;
    assign issue = head_v & i_z_r & ack_ok;

`ifdef CORY_SRAM_WO_ACK_EN
    logic [BW-1:0] ack_cnt_q, ack_cnt_d;
    logic          ack_pop;

    assign o_b_v   = (ack_cnt_q != '0);
    assign o_b_cnt = ack_cnt_q;
    assign ack_pop = o_b_v & i_b_r;
    // A returning ack frees a slot in the same cycle, so a full counter can still issue.
    assign ack_ok  = (ack_cnt_q < BW'(B)) | ack_pop;

    // Outstanding-ack count: +1 per commit, -1 per accepted ack.
    always_comb begin
        ack_cnt_d = ack_cnt_q;
        case ({issue, ack_pop})
            2'b10:   ack_cnt_d = ack_cnt_q + 1'b1;
            2'b01:   ack_cnt_d = ack_cnt_q - 1'b1;
            default: ack_cnt_d = ack_cnt_q;
        endcase
    end

    // Ack counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_cnt_q <= '0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
        end
    end
`else
    logic unused_b_r;

    assign unused_b_r = i_b_r;
    assign ack_ok     = 1'b1;
    assign o_b_v      = 1'b0;
    assign o_b_cnt    = '0;
`endif

    // SRAM port mux: strobes only while issuing; address/data follow the head, zero when empty.
    // Reset empties the queue asynchronously, so the strobes drop to all ones at once.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        o_z_cen   = '1;
        o_z_wen   = '1;
        o_z_addr  = '0;
        o_z_wdata = '0;
        if (head_v) begin
            o_z_addr  = head_addr;
            o_z_wdata = head_wdata;
        end
        if (issue) begin
            o_z_cen = head_cen;
            o_z_wen = head_cen;
        end
    end

endmodule

// File: tb/tb_cory_sram_wo.sv
// Self-checking bench for cory_sram_wo. Committed writes are compared against a
// scoreboard of accepted requests; ack-channel scenarios are selected by
// CORY_SRAM_WO_ACK_EN, matching the DUT build.
module tb_cory_sram_wo;

    typedef struct packed {
        logic [1:0] cen;
        logic [7:0] addr;
        logic [7:0] wdata;
    } req_t;

    logic       clk;
    logic       reset_n;
    logic [1:0] i_s_cen;
    logic [7:0] i_s_addr;
    logic [7:0] i_s_wdata;
    logic       o_s_r;
    logic [1:0] o_z_cen;
    logic [1:0] o_z_wen;
    logic [7:0] o_z_addr;
    logic [7:0] o_z_wdata;
    logic       i_z_r;
    logic       o_b_v;
    logic       i_b_r;
    logic [1:0] o_b_cnt;

    int   n_checks;
    int   n_errors;
    int   n_commit;
    int   cyc;
    req_t exp_q[$];
    int   commit_cyc[$];

    cory_sram_wo #(.C(2), .A(8), .D(8), .Q(2), .B(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_s_cen   (i_s_cen),
        .i_s_addr  (i_s_addr),
        .i_s_wdata (i_s_wdata),
        .o_s_r     (o_s_r),
        .o_z_cen   (o_z_cen),
        .o_z_wen   (o_z_wen),
        .o_z_addr  (o_z_addr),
        .o_z_wdata (o_z_wdata),
        .i_z_r     (i_z_r),
        .o_b_v     (o_b_v),
        .i_b_r     (i_b_r),
        .o_b_cnt   (o_b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Commit monitor: a strobe seen at the negedge commits on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && (o_z_cen !== 2'b11)) begin
            req_t e;
            n_checks++;
            if (o_z_wen !== o_z_cen) begin
                n_errors++;
                $display("FAIL wen_eq_cen: got wen=%b cen=%b", o_z_wen, o_z_cen);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL spurious_write: got cen=%b addr=%h wdata=%h, expected no write",
                         o_z_cen, o_z_addr, o_z_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({o_z_cen, o_z_addr, o_z_wdata} !== e) begin
                    n_errors++;
                    $display("FAIL commit_data: got cen=%b addr=%h wdata=%h, expected cen=%b addr=%h wdata=%h",
                             o_z_cen, o_z_addr, o_z_wdata, e.cen, e.addr, e.wdata);
                end
            end
            n_commit++;
            commit_cyc.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one request until accepted (bounded); records it on the scoreboard.
    task automatic drive_req(input req_t r, output int acc_cyc);
        logic rdy;
        logic done;
        done      = 1'b0;
        acc_cyc   = -1;
        i_s_cen   = r.cen;
        i_s_addr  = r.addr;
        i_s_wdata = r.wdata;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            rdy = o_s_r;
            @(posedge clk);
            #1;
            if (rdy) begin
                exp_q.push_back(r);
                acc_cyc = cyc;
                done    = 1'b1;
            end
        end
        i_s_cen = 2'b11;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no accept for addr=%h, expected accept within 50 cycles", r.addr);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending writes, expected 0", exp_q.size());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        i_s_cen   = 2'b11;
        i_s_addr  = '0;
        i_s_wdata = '0;
        i_z_r     = 1'b0;
        i_b_r     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_s_r", 32'(o_s_r), 32'd1);
        chk("reset_z_cen", 32'(o_z_cen), 32'h3);
        chk("reset_z_wen", 32'(o_z_wen), 32'h3);
        chk("reset_z_addr", 32'(o_z_addr), 32'h0);
        chk("reset_z_wdata", 32'(o_z_wdata), 32'h0);
        chk("reset_b_v", 32'(o_b_v), 32'd0);
        chk("reset_b_cnt", 32'(o_b_cnt), 32'd0);
    endtask

    task automatic test_single_write();
        int acc;
        @(posedge clk);
        #1;
        i_z_r = 1'b1;
        i_b_r = 1'b1;
        drive_req('{cen: 2'b10, addr: 8'h3C, wdata: 8'hA5}, acc);
        @(negedge clk);
        chk("single_cen", 32'(o_z_cen), 32'h2);
        chk("single_wen", 32'(o_z_wen), 32'h2);
        chk("single_addr", 32'(o_z_addr), 32'h3C);
        chk("single_wdata", 32'(o_z_wdata), 32'hA5);
        chk("single_b_v_at_commit", 32'(o_b_v), 32'd0);
        @(negedge clk);
        chk("single_cen_after", 32'(o_z_cen), 32'h3);
`ifdef CORY_SRAM_WO_ACK_EN
        chk("single_b_v_after_commit", 32'(o_b_v), 32'd1);
`else
        chk("single_b_v_after_commit", 32'(o_b_v), 32'd0);
`endif
        @(negedge clk);
        chk("single_b_v_later", 32'(o_b_v), 32'd0);
        chk("single_empty_addr", 32'(o_z_addr), 32'h0);
    endtask

    task automatic test_queue_full();
        int acc;
        @(posedge clk);
        #1;
        i_z_r = 1'b0;
        drive_req('{cen: 2'b01, addr: 8'h11, wdata: 8'h22}, acc);
        drive_req('{cen: 2'b00, addr: 8'h33, wdata: 8'h44}, acc);
        @(negedge clk);
        chk("full_s_r", 32'(o_s_r), 32'd0);
        chk("full_no_strobe", 32'(o_z_cen), 32'h3);
        chk("full_head_addr", 32'(o_z_addr), 32'h11);
        chk("full_head_wdata", 32'(o_z_wdata), 32'h22);
        @(posedge clk);
        #1;
        i_z_r = 1'b1;
        drive_req('{cen: 2'b10, addr: 8'h55, wdata: 8'h66}, acc);
        wait_drain();
        @(negedge clk);
        chk("full_drained_s_r", 32'(o_s_r), 32'd1);
        chk("full_drained_addr", 32'(o_z_addr), 32'h0);
        chk("full_drained_wdata", 32'(o_z_wdata), 32'h0);
    endtask

    task automatic test_reset_mid_stream();
        int acc;
        int snap;
        @(posedge clk);
        #1;
        i_z_r = 1'b0;
        i_b_r = 1'b0;
        drive_req('{cen: 2'b10, addr: 8'h77, wdata: 8'h88}, acc);
        drive_req('{cen: 2'b01, addr: 8'h99, wdata: 8'hAA}, acc);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        i_z_r   = 1'b1;
        #1;
        chk("rst_mid_cen", 32'(o_z_cen), 32'h3);
        chk("rst_mid_wen", 32'(o_z_wen), 32'h3);
        chk("rst_mid_b_v", 32'(o_b_v), 32'd0);
        chk("rst_mid_addr", 32'(o_z_addr), 32'h0);
        exp_q.delete();
        snap = n_commit;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_no_stale", 32'(n_commit - snap), 32'd0);
        chk("rst_mid_s_r", 32'(o_s_r), 32'd1);
        chk("rst_mid_b_cnt", 32'(o_b_cnt), 32'd0);
    endtask

`ifndef CORY_SRAM_WO_ACK_EN
    task automatic test_back_to_back();
        int acc;
        int first_acc;
        int base;
        int cbase;
        req_t r;
        @(posedge clk);
        #1;
        i_z_r = 1'b1;
        i_b_r = 1'b0;
        base  = n_commit;
        cbase = commit_cyc.size();
        for (int i = 0; i < 5; i++) begin
            r = '{cen: 2'(i % 3), addr: 8'(8'hC0 + i), wdata: 8'(8'h10 * i + 1)};
            drive_req(r, acc);
            if (i == 0) first_acc = acc;
            chk("b2b_b_v", 32'(o_b_v), 32'd0);
        end
        wait_drain();
        @(negedge clk);
        chk("b2b_commits", 32'(n_commit - base), 32'd5);
        chk("b2b_b_cnt", 32'(o_b_cnt), 32'd0);
        if (commit_cyc.size() >= cbase + 5) begin
            chk("b2b_first_latency", 32'(commit_cyc[cbase]), 32'(first_acc));
            chk("b2b_rate", 32'(commit_cyc[cbase + 4] - commit_cyc[cbase]), 32'd4);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL b2b_commit_log: got %0d entries, expected %0d", commit_cyc.size() - cbase, 5);
        end
    endtask
`else
    task automatic test_ack_backpressure();
        int acc;
        int base;
        @(posedge clk);
        #1;
        i_b_r = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_b_r = 1'b0;
        i_z_r = 1'b1;
        base  = n_commit;
        drive_req('{cen: 2'b10, addr: 8'h01, wdata: 8'hF1}, acc);
        drive_req('{cen: 2'b01, addr: 8'h02, wdata: 8'hF2}, acc);
        drive_req('{cen: 2'b00, addr: 8'h03, wdata: 8'hF3}, acc);
        drive_req('{cen: 2'b10, addr: 8'h04, wdata: 8'hF4}, acc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_commits", 32'(n_commit - base), 32'd2);
        chk("bp_b_cnt", 32'(o_b_cnt), 32'd2);
        chk("bp_no_strobe", 32'(o_z_cen), 32'h3);
        chk("bp_s_r", 32'(o_s_r), 32'd0);
        @(posedge clk);
        #1;
        i_b_r = 1'b1;
        @(negedge clk);
        chk("bp_pulse_strobe", 32'(o_z_cen), 32'h0);
        @(posedge clk);
        #1;
        i_b_r = 1'b0;
        chk("bp_pulse_commits", 32'(n_commit - base), 32'd3);
        chk("bp_pulse_b_cnt", 32'(o_b_cnt), 32'd2);
        i_b_r = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("bp_acks_drained", 32'(o_b_cnt), 32'd0);
    endtask

    task automatic test_simultaneous();
        int acc;
        @(posedge clk);
        #1;
        i_b_r = 1'b0;
        i_z_r = 1'b1;
        drive_req('{cen: 2'b01, addr: 8'hA0, wdata: 8'h0A}, acc);
        @(posedge clk);
        #1;
        i_z_r = 1'b0;
        drive_req('{cen: 2'b10, addr: 8'hB0, wdata: 8'h0B}, acc);
        @(negedge clk);
        chk("sim_pre_b_cnt", 32'(o_b_cnt), 32'd1);
        @(posedge clk);
        #1;
        i_z_r = 1'b1;
        i_b_r = 1'b1;
        drive_req('{cen: 2'b00, addr: 8'hC0, wdata: 8'h0C}, acc);
        i_z_r = 1'b0;
        i_b_r = 1'b0;
        @(negedge clk);
        chk("sim_b_cnt", 32'(o_b_cnt), 32'd1);
        chk("sim_s_r", 32'(o_s_r), 32'd1);
        chk("sim_head_addr", 32'(o_z_addr), 32'hC0);
        @(posedge clk);
        #1;
        i_z_r = 1'b1;
        i_b_r = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("sim_acks_drained", 32'(o_b_cnt), 32'd0);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_commit = 0;
        cyc      = 0;
        test_reset();
        test_single_write();
        test_queue_full();
`ifdef CORY_SRAM_WO_ACK_EN
        test_ack_backpressure();
        test_simultaneous();
`else
        test_back_to_back();
`endif
        test_reset_mid_stream();
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cory_sram_wo.md
Name: cory_sram_wo

Overview:
- Write-only SRAM adapter with a valid/ready request side and a write-acknowledge response side.
- Accepts write requests (chip selects, address, data) on a valid/ready channel and buffers them in a Q-deep request queue.
- Drains the queue into the SRAM write port when the SRAM is ready, and returns one acknowledge token per committed write.
- Counterpart of the read-only SRAM adapter; the two share an SRAM macro through an external arbiter.

Parameters:
- C, 2, number of chip-select bits (banks); active-low.
- A, 8, address bits.
- D, 8, data bits.
- Q, 2, request queue depth; must be ≥1.
- B, 2, maximum outstanding (unreturned) acknowledges; must be ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_s_cen  input  C  request chip selects, active-low; request valid when any bit is 0.
- i_s_addr  input  A  request address.
- i_s_wdata  input  D  request write data.
- o_s_r  output  1  request ready.
- o_z_cen  output  C  SRAM chip selects, active-low.
- o_z_wen  output  C  SRAM write enables, active-low.
- o_z_addr  output  A  SRAM address.
- o_z_wdata  output  D  SRAM write data.
- i_z_r  input  1  SRAM/arbiter ready; a write commits on an edge where it is 1 and o_z_cen has any 0.
- o_b_v  output  1  acknowledge valid.
- i_b_r  input  1  acknowledge ready.
- o_b_cnt  output  $clog2(B+1)  outstanding acknowledge count.

Behaviour:
- Single clock clk; reset_n is asynchronous, active-low.
- Reset values: queue empty, ack count 0, o_s_r=1, o_z_cen and o_z_wen all ones, o_z_addr=0, o_z_wdata=0, o_b_v=0, o_b_cnt=0.
- Request valid: s_v = (&i_s_cen == 0).
  - o_s_r = !queue_full, independent of s_v.
  - Push on s_v & o_s_r; the entry stores {i_s_cen, i_s_addr, i_s_wdata}.
  - Multiple low cen bits are legal (broadcast write) and pass through unchanged.
- Issue condition, combinational: issue = head_v & i_z_r & ack_ok, where ack_ok = (ack_cnt < B) | (o_b_v & i_b_r).
  - With ACK disabled, ack_ok = 1.
- SRAM outputs when issue=1: o_z_cen = head_cen, o_z_wen = head_cen, o_z_addr = head_addr, o_z_wdata = head_wdata.
- SRAM outputs when issue=0: o_z_cen and o_z_wen all ones; o_z_addr and o_z_wdata hold head fields, or 0 when empty.
- Pop on issue. Latency: a request accepted at edge T commits at the earliest at edge T+1. There is no same-cycle bypass.
- Queue:
  - Simultaneous push and pop keeps the count.
  - When full, o_s_r=0; a pop in the same cycle does not raise o_s_r combinationally.
  - Pointers wrap modulo Q.
- Acknowledge counter ack_cnt, range 0..B:
  - +1 on issue, −1 on o_b_v & i_b_r; both together leave it unchanged.
  - o_b_v = (ack_cnt != 0). o_b_cnt = ack_cnt.
  - The ack for a write becomes visible on the cycle after its commit edge.
- Back-pressure: with ack_cnt == B and i_b_r = 0, no issue occurs; o_z_cen stays all ones while the queue may still fill.
- Reset asserted mid-operation:
  - o_z_cen and o_z_wen go all ones immediately (asynchronously).
  - Queued writes and pending acks are discarded, with no partial commit.
- The adapter never reorders: acks correspond 1:1, in order, to committed writes.

Optional Feature:
- Macro: CORY_SRAM_WO_ACK_EN.
- Defined: acknowledge channel and ack_cnt back-pressure behave as above.
- Undefined:
  - ack_cnt logic is removed; o_b_v = 0 and o_b_cnt = 0 constant; i_b_r is ignored.
  - ack_ok = 1, so issue = head_v & i_z_r.

Decomposition:
- No package types. Shared widths are localparams: QW = C+A+D (queue entry width) and BW = $clog2(B+1).
- One natural sub-module: the existing cory_queue_cnt with N=QW and Q=Q holds the request queue.
  - Its o_a_r drives o_s_r; o_z_v/o_z_d provide head_v/head fields; i_z_r is driven by issue.
- Ack counter, issue logic and output muxing live in cory_sram_wo itself.

Test Plan:
- Single write: i_s_cen=2'b10, addr=8'h3C, wdata=8'hA5 for one cycle with i_z_r=1, i_b_r=1 → next cycle o_z_cen=o_z_wen=2'b10, o_z_addr=8'h3C, o_z_wdata=8'hA5; the following cycle o_b_v=1 for exactly one cycle.
- Queue full: i_z_r=0, push 3 requests (Q=2) → o_s_r=0 after 2 accepts, third held; raise i_z_r → entries drain in order, third accepted once o_s_r returns to 1.
- Ack back-pressure (ACK_EN, B=2): i_b_r=0, 4 writes with i_z_r=1 → exactly 2 commits, o_b_cnt=2, o_z_cen all ones afterwards; pulse i_b_r one cycle → one more commit same cycle, o_b_cnt stays 2.
- Simultaneous events: with 1 entry queued, ack_cnt=1, drive push + issue + ack pop in the same cycle → queue count and ack_cnt both unchanged; data order preserved.
- Reset mid-stream: assert reset_n=0 between clock edges with 2 queued writes → o_z_cen/o_z_wen all ones immediately, o_b_v=0; after release no stale write appears, o_s_r=1.
- ACK_EN undefined: i_b_r=0 held, 5 back-to-back writes with i_z_r=1 → all 5 commit at 1 per cycle after first-cycle latency, o_b_v stays 0.
